// File: rtl/press_event_reader.sv
// Button press capture for the Simon game: sync + debounce per channel, sticky
// pending flags, and a single output slot that hands presses out lowest index first.
module press_event_reader #(
  parameter int WIDTH    = 4,
  parameter int DEBOUNCE = 500000,
  parameter int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn,
  input  logic             clear,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_index,
  output logic [WIDTH-1:0] evt_onehot,
  output logic [WIDTH-1:0] pending,
  output logic             overflow
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] r_deb;
  logic [CNT_W-1:0] r_cnt [WIDTH];

  logic [WIDTH-1:0] r_pending;
  logic             r_valid;
  logic [IDX_W-1:0] r_index;
  logic [WIDTH-1:0] r_onehot;
  logic             r_overflow;

  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_sel_oh;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_load;
  logic [WIDTH-1:0] w_take;

  // Synchroniser and debounce survive clear; only reset restarts them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_deb <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
      for (int i = 0; i < WIDTH; i++) begin
        if (r_s2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          r_deb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // A press is the edge on which the debounced level is about to go 0 -> 1.
  always_comb begin
    w_rise = '0;
    for (int i = 0; i < WIDTH; i++)
      w_rise[i] = r_s2[i] && !r_deb[i] && (r_cnt[i] == CNT_LAST);
  end

  always_comb begin
    w_sel_oh  = r_pending & (~r_pending + WIDTH'(1));
    w_sel_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--)
      if (r_pending[i]) w_sel_idx = IDX_W'(i);
  end

  assign w_load = !r_valid || evt_ready;
  assign w_take = w_load ? w_sel_oh : '0;

  // A press only counts as overflow if its pending bit stays set this edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending  <= '0;
      r_valid    <= 1'b0;
      r_index    <= '0;
      r_onehot   <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_pending  <= '0;
      r_valid    <= 1'b0;
      r_index    <= '0;
      r_onehot   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_pending <= (r_pending & ~w_take) | w_rise;
      if (|(w_rise & r_pending & ~w_take)) r_overflow <= 1'b1;
      if (w_load) begin
        if (|r_pending) begin
          r_valid  <= 1'b1;
          r_index  <= w_sel_idx;
          r_onehot <= w_sel_oh;
        end else begin
          r_valid  <= 1'b0;
          r_onehot <= '0;
        end
      end
    end
  end

  assign evt_valid  = r_valid;
  assign evt_index  = r_index;
  assign evt_onehot = r_onehot;
  assign pending    = r_pending;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_press_event_reader.sv
// Scoreboarded bench for press_event_reader with a short debounce window.
module tb_press_event_reader;

  localparam int WIDTH    = 4;
  localparam int DEBOUNCE = 4;
  localparam int IDX_W    = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] btn;
  logic             clear;
  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_index;
  logic [WIDTH-1:0] evt_onehot;
  logic [WIDTH-1:0] pending;
  logic             overflow;

  int n_total = 0;
  int n_bad   = 0;
  int exp_q[$];

  press_event_reader #(.WIDTH(WIDTH), .DEBOUNCE(DEBOUNCE), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .btn(btn), .clear(clear),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_index(evt_index),
    .evt_onehot(evt_onehot), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs change just after a rising edge, so each call lands after the next edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Handshake monitor: mid-cycle values decide whether the next edge accepts.
  always @(negedge clk) begin
    if (!evt_valid) chk("onehot_idle", 32'(evt_onehot), 0);
    if (!reset && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        chk("evt_extra", 32'(evt_index), 99);
      end else begin
        int e;
        e = exp_q.pop_front();
        chk("evt_index", 32'(evt_index), 32'(e));
        chk("evt_onehot", 32'(evt_onehot), 32'(1) << e);
      end
    end
  end

  initial begin
    reset = 1'b1; btn = '0; clear = 1'b0; evt_ready = 1'b0;
    step(3);
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_index", 32'(evt_index), 0);
    reset = 1'b0;
    step(2);

    // Single press, latency check
    btn = 4'b0100;
    exp_q.push_back(2);
    step(5);
    chk("lat_pend_e4", 32'(pending), 0);
    step();
    chk("lat_pend_e5", 32'(pending), 4'b0100);
    chk("lat_valid_e5", 32'(evt_valid), 0);
    step();
    chk("lat_valid_e6", 32'(evt_valid), 1);
    chk("lat_index_e6", 32'(evt_index), 2);
    chk("lat_onehot_e6", 32'(evt_onehot), 4'b0100);
    chk("lat_pend_e6", 32'(pending), 0);
    evt_ready = 1'b1;
    step();
    chk("lat_valid_e7", 32'(evt_valid), 0);
    btn = '0;
    step(10);
    chk("single_q", exp_q.size(), 0);

    // Bounce shorter than the window
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      step(2);
    end
    btn = '0;
    step(10);
    chk("bounce_pend", 32'(pending), 0);
    chk("bounce_valid", 32'(evt_valid), 0);

    // Simultaneous presses drain back-to-back
    btn = 4'b1011;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
    step(6);
    chk("multi_pend_e5", 32'(pending), 4'b1011);
    step();
    chk("multi_idx_e6", 32'(evt_index), 0);
    step();
    chk("multi_idx_e7", 32'(evt_index), 1);
    step();
    chk("multi_idx_e8", 32'(evt_index), 3);
    step();
    chk("multi_valid_e9", 32'(evt_valid), 0);
    btn = '0;
    step(10);
    chk("multi_q", exp_q.size(), 0);

    // Backpressure with a second press queued behind
    evt_ready = 1'b0;
    btn = 4'b0010;
    exp_q.push_back(1);
    step(7);
    chk("bp_valid", 32'(evt_valid), 1);
    btn = 4'b1010;
    exp_q.push_back(3);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_idx", 32'(evt_index), 1);
      chk("bp_hold_valid", 32'(evt_valid), 1);
    end
    chk("bp_pend", 32'(pending), 4'b1000);
    evt_ready = 1'b1;
    step();
    chk("bp_next_idx", 32'(evt_index), 3);
    chk("bp_next_valid", 32'(evt_valid), 1);
    step();
    chk("bp_drained", 32'(evt_valid), 0);
    btn = '0;
    step(10);
    chk("bp_q", exp_q.size(), 0);

    // Merged press sets overflow; clear flushes
    evt_ready = 1'b0;
    btn = 4'b0100;
    step(8);
    chk("ovf_slot_idx", 32'(evt_index), 2);
    btn = '0; step(8);
    btn = 4'b0100; step(8);
    chk("ovf_pend_mid", 32'(pending), 4'b0100);
    chk("ovf_clear_pre", 32'(overflow), 0);
    btn = '0; step(8);
    btn = 4'b0100; step(8);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_pend", 32'(pending), 4'b0100);
    btn = '0; step(8);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_overflow", 32'(overflow), 0);
    chk("clr_pending", 32'(pending), 0);
    chk("clr_valid", 32'(evt_valid), 0);
    step(4);
    chk("clr_stays_idle", 32'(evt_valid), 0);

    // Reset mid-operation
    btn = 4'b0001;
    step(8);
    chk("rm_slot", 32'(evt_valid), 1);
    btn = 4'b0111;
    step(8);
    chk("rm_pend", 32'(pending), 4'b0110);
    btn = 4'b0010;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rm_valid", 32'(evt_valid), 0);
    chk("rm_pending", 32'(pending), 0);
    chk("rm_onehot", 32'(evt_onehot), 0);
    chk("rm_index", 32'(evt_index), 0);
    step(6);
    chk("rm_pend_r6", 32'(pending), 4'b0010);
    chk("rm_valid_r6", 32'(evt_valid), 0);
    step();
    chk("rm_valid_r7", 32'(evt_valid), 1);
    chk("rm_index_r7", 32'(evt_index), 1);
    exp_q.push_back(1);
    evt_ready = 1'b1;
    step();
    chk("rm_drained", 32'(evt_valid), 0);
    btn = '0;
    step(10);
    chk("rm_overflow", 32'(overflow), 0);
    chk("final_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/press_event_reader.md
Name: press_event_reader

Overview:
- Consumer side of the button set-latch path in the Simon game.
- Per button: synchronises and debounces the raw input, and captures each press as a sticky pending flag (set on press, cleared on read).
- Presents pending presses to the game FSM one at a time over a valid/ready handshake, lowest index first.
- Sits between the board button pins and the game-control FSM.

Parameters:
WIDTH, 4, number of button channels (1..16)
DEBOUNCE, 500000, consecutive clk cycles a synchronised level must differ from the debounced level before it is accepted (>=1; 5 ms at 100 MHz)
IDX_W, clog2(WIDTH) (min 1), width of evt_index

Ports:
clk  input  1  system clock, all logic rising-edge
reset  input  1  synchronous, active-high; clears all state
btn  input  WIDTH  raw asynchronous button levels, 1 = pressed
clear  input  1  synchronous flush of pending, output event and overflow
evt_valid  output  1  an event is presented
evt_ready  input  1  consumer accepts the event when high with evt_valid
evt_index  output  IDX_W  channel number of the presented event
evt_onehot  output  WIDTH  one-hot form of evt_index; all zero when evt_valid=0
pending  output  WIDTH  pending flags not yet loaded into the output slot
overflow  output  1  sticky; a press arrived on a channel whose pending flag was already set

Behaviour:
- Reset values: all sync flops, debounced levels, counters, pending, evt_valid, evt_index, evt_onehot and overflow are 0.
- Synchroniser: per channel, two flops, s1<=btn, s2<=s1.
- Debounce, per channel, counter cnt of width clog2(DEBOUNCE+1):
  - If s2==deb: cnt<=0.
  - Else if cnt==DEBOUNCE-1: deb<=s2 and cnt<=0.
  - Else: cnt<=cnt+1.
  - Any bounce back to the deb level restarts the count.
- Press detect: on the edge where deb goes 0->1, the channel's pending bit is set. Releases (1->0) generate no event.
- A button held through reset produces exactly one event after reset is released, because deb starts at 0.
- Output slot (one register set: evt_valid, evt_index, evt_onehot), load condition:
  - Load when evt_valid==0, or when evt_valid&&evt_ready.
  - If pending!=0, load the lowest-index pending bit: evt_valid<=1 and clear that pending bit on the same edge.
  - Otherwise, if loading on accept, evt_valid<=0.
- Handshake: while evt_valid=1 and evt_ready=0, evt_index and evt_onehot hold stable. Back-to-back accepts deliver one event per cycle.
- Latency: btn held high from before edge 0 (first s1 sample); s2=1 after edge 1; deb=1 and pending set at edge DEBOUNCE+1; evt_valid=1 after edge DEBOUNCE+2 when the slot is free.
- Same-channel press:
  - Press while the channel is in the output slot (its pending bit is clear): sets pending again and yields a second event later.
  - Press while the channel's pending bit is already 1: pending stays 1 and overflow<=1 (the press is merged).
- Simultaneous events on one edge:
  - A new press sets pending on the same edge that another channel's bit is loaded into the slot; both take effect.
  - Loading a channel and a new press on that same channel: pending ends at 1, and overflow is not set.
- clear (priority below reset, above all else): pending<=0, evt_valid<=0, evt_onehot<=0, overflow<=0. Presses detected on that edge are dropped. Synchroniser and debounce state are kept.
- Reset mid-operation: next state equals the reset state regardless of handshake or counter progress.

Test Plan:
- DEBOUNCE=4, btn=4'b0100 held from edge 0 -> evt_valid=1, evt_index=2, evt_onehot=4'b0100 after edge 6; evt_ready=1 at edge 7 -> evt_valid=0 after edge 7; exactly one event.
- DEBOUNCE=4, btn[0] toggles every 2 cycles for 20 cycles then held 0 -> no event; pending stays 0.
- btn=4'b1011 rise together, evt_ready held 1 -> events index 0, 1, 3 on three consecutive cycles; then evt_valid=0.
- evt_ready=0 for 10 cycles with event index 1 presented, btn[3] pressed meanwhile -> index 1 stable throughout and pending=4'b1000; on accept, next cycle presents index 3.
- Channel 2 pressed, released, pressed again while its first event is unaccepted and pending[2]=1 from an intermediate press -> overflow=1; clear pulse -> overflow=0, pending=0, evt_valid=0.
- reset asserted one cycle while evt_valid=1 and pending=4'b0110 -> all outputs 0 next cycle; with btn[1] still held, one index-1 event appears DEBOUNCE+3 edges after reset deasserts.
